// File: rtl/mgpu_mtrx_pkg.sv
// Shared types and packing helpers for the point-packing and matrix-transform stages.
// Matrices are column-major: element (r,c) has index k = 4c + r, with element (0,0) in the MSBs.
package mgpu_mtrx_pkg;

  localparam int WIDTH  = 21;
  localparam int FRAC   = 10;
  localparam int MTRX_W = 16 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = 21'h000400;

  typedef logic signed [WIDTH-1:0] elem_t;
  typedef logic [MTRX_W-1:0] mtrx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } xf_state_t;

  function automatic elem_t elem_get(input mtrx_t m, input logic [1:0] r, input logic [1:0] c);
    int k;
    k = int'({c, r});
    return elem_t'(m[MTRX_W-1-WIDTH*k -: WIDTH]);
  endfunction

  function automatic mtrx_t elem_set(input mtrx_t m, input logic [1:0] r, input logic [1:0] c,
                                     input elem_t v);
    int k;
    mtrx_t res;
    k = int'({c, r});
    res = m;
    res[MTRX_W-1-WIDTH*k -: WIDTH] = v;
    return res;
  endfunction

endpackage

// File: rtl/mtrx_xform_seq_if.sv
// Valid/ready handshake bundle for the matrix transform stage.
// slave = the transform block, master = upstream producer plus downstream consumer.
interface mtrx_xform_seq_if;
  import mgpu_mtrx_pkg::*;

  logic  in_valid;
  logic  in_ready;
  mtrx_t in_mtrx;
  mtrx_t xf_mtrx;
  logic  out_valid;
  logic  out_ready;
  mtrx_t out_mtrx;
  logic  out_ovf;

  modport slave (
    input  in_valid, in_mtrx, xf_mtrx, out_ready,
    output in_ready, out_valid, out_mtrx, out_ovf
  );

  modport master (
    output in_valid, in_mtrx, xf_mtrx, out_ready,
    input  in_ready, out_valid, out_mtrx, out_ovf
  );

endinterface

// File: rtl/mtrx_dot4.sv
// Four-term fixed-point dot product with floor shift by FRAC and range reduction to WIDTH.
// MTRX_SAT_EN defined: clamp to the signed range; undefined: keep the low bits (wrap). ovf flags either way.
module mtrx_dot4
  import mgpu_mtrx_pkg::*;
(
  input  logic [4*WIDTH-1:0] t_row,
  input  logic [4*WIDTH-1:0] m_col,
  output elem_t              result,
  output logic               ovf
);

  localparam int SUM_W = 2*WIDTH + 2;
  localparam int SHR_W = SUM_W - FRAC;

  logic signed [SUM_W-1:0] sum;
  logic signed [SHR_W-1:0] shr;
  elem_t                   t_e;
  elem_t                   m_e;

  always_comb begin
    sum = '0;
    t_e = '0;
    m_e = '0;
    for (int j = 0; j < 4; j++) begin
      t_e = elem_t'(t_row[j*WIDTH +: WIDTH]);
      m_e = elem_t'(m_col[j*WIDTH +: WIDTH]);
      sum = sum + (SUM_W'(t_e) * SUM_W'(m_e));
    end
    shr = SHR_W'(sum >>> FRAC);
  end

  // In range only when every bit above the element's sign bit matches it.
  assign ovf = !((&shr[SHR_W-1:WIDTH-1]) || !(|shr[SHR_W-1:WIDTH-1]));

`ifdef MTRX_SAT_EN
  assign result = ovf ? (shr[SHR_W-1] ? elem_t'(21'h100000) : elem_t'(21'h0FFFFF))
                      : elem_t'(shr[WIDTH-1:0]);
`else
  assign result = elem_t'(shr[WIDTH-1:0]);
`endif

endmodule

// File: rtl/mtrx_xform_seq.sv
// Sequential 4x4 transform R = T x M, one output element per cycle through a shared dot4.
// Saturating vs wrapping element reduction is selected by MTRX_SAT_EN (see mtrx_dot4).
//
// state | meaning
// IDLE  | in_ready=1, waiting for a job; accept latches M and T
// CALC  | element idx of R written each cycle, idx 0..15
// DONE  | out_valid=1, holding result until out_ready
module mtrx_xform_seq
  import mgpu_mtrx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mtrx_xform_seq_if.slave    bus
);

  xf_state_t         state;
  logic [3:0]        idx;
  mtrx_t             m_reg;
  mtrx_t             t_reg;
  mtrx_t             res;
  logic              ovf_sticky;
  logic              out_valid_r;
  logic              in_ready_r;
  logic [4*WIDTH-1:0] t_row;
  logic [4*WIDTH-1:0] m_col;
  elem_t             dot_val;
  logic              dot_ovf;

  // Row r = idx[1:0] of T against column c = idx[3:2] of M.
  always_comb begin
    t_row = '0;
    m_col = '0;
    for (int j = 0; j < 4; j++) begin
      t_row[j*WIDTH +: WIDTH] = elem_get(t_reg, idx[1:0], 2'(j));
      m_col[j*WIDTH +: WIDTH] = elem_get(m_reg, 2'(j), idx[3:2]);
    end
  end

  mtrx_dot4 u_dot4 (
    .t_row  (t_row),
    .m_col  (m_col),
    .result (dot_val),
    .ovf    (dot_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      m_reg       <= '0;
      t_reg       <= '0;
      res         <= '0;
      ovf_sticky  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m_reg      <= bus.in_mtrx;
            t_reg      <= bus.xf_mtrx;
            idx        <= '0;
            ovf_sticky <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          res <= elem_set(res, idx[1:0], idx[3:2], dot_val);
          if (dot_ovf) ovf_sticky <= 1'b1;
          idx <= idx + 4'd1;
          if (idx == 4'd15) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_mtrx  = res;
  assign bus.out_ovf   = ovf_sticky;

endmodule

// File: tb/tb_mtrx_xform_seq.sv
// Directed bench for mtrx_xform_seq: vector table of hand-computed transforms plus
// backpressure and mid-job reset sequences. Expected overflow values follow MTRX_SAT_EN.
module tb_mtrx_xform_seq;
  import mgpu_mtrx_pkg::*;

  typedef struct {
    mtrx_t t;
    mtrx_t m;
    mtrx_t r;
    logic  ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [7];

  mtrx_xform_seq_if bus ();

  mtrx_xform_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4*WIDTH-1:0] cv(input logic [WIDTH-1:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic check_m(input string nm, input mtrx_t act, input mtrx_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic start_job(input mtrx_t t, input mtrx_t m);
    int n;
    n = 0;
    @(negedge clk);
    bus.xf_mtrx  = t;
    bus.in_mtrx  = m;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_i("accept_wait_bound", int'(n < 40), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.xf_mtrx  = ~t;
    bus.in_mtrx  = ~m;
    check_i("in_ready_low_after_accept", int'(bus.in_ready), 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_i("in_ready_after_hs", int'(bus.in_ready), 1);
    check_i("out_valid_after_hs", int'(bus.out_valid), 0);
  endtask

  initial begin
    mtrx_t ident, pts, exp_r;
    int    lat;
    logic [WIDTH-1:0] pos_ovf_v, neg_ovf_v;

`ifdef MTRX_SAT_EN
    pos_ovf_v = 21'h0FFFFF;
    neg_ovf_v = 21'h100000;
`else
    pos_ovf_v = 21'h1FFFFE;
    neg_ovf_v = 21'h000000;
`endif

    ident = {cv(ONE, 0, 0, 0), cv(0, ONE, 0, 0), cv(0, 0, ONE, 0), cv(0, 0, 0, ONE)};
    pts   = {4{cv(21'h400, 21'h800, 21'hC00, 21'h400)}};

    // identity
    vecs[0] = '{t: ident, m: pts, r: pts, ovf: 1'b0};
    // scale x2 with negative Y
    vecs[1] = '{t: {cv(21'h800, 0, 0, 0), cv(0, 21'h800, 0, 0), cv(0, 0, 21'h800, 0), cv(0, 0, 0, 21'h400)},
                m: {4{cv(21'h400, 21'h1FFE00, 21'h200, 21'h400)}},
                r: {4{cv(21'h800, 21'h1FFC00, 21'h400, 21'h400)}}, ovf: 1'b0};
    // translate X by +5.0
    vecs[2] = '{t: {cv(21'h400, 0, 0, 0), cv(0, 21'h400, 0, 0), cv(0, 0, 21'h400, 0), cv(21'h1400, 0, 0, 21'h400)},
                m: pts, r: {4{cv(21'h1800, 21'h800, 21'hC00, 21'h400)}}, ovf: 1'b0};
    // 90 degree rotation about Z: x' = -y, y' = x
    vecs[3] = '{t: {cv(0, 21'h400, 0, 0), cv(21'h1FFC00, 0, 0, 0), cv(0, 0, 21'h400, 0), cv(0, 0, 0, 21'h400)},
                m: pts, r: {4{cv(21'h1FF800, 21'h400, 21'hC00, 21'h400)}}, ovf: 1'b0};
    // halving one LSB: -0.5 LSB floors to -1, +0.5 LSB floors to 0
    vecs[4] = '{t: {cv(21'h200, 0, 0, 0), cv(0, 21'h200, 0, 0), cv(0, 0, 21'h400, 0), cv(0, 0, 0, 21'h400)},
                m: {4{cv(21'h1FFFFF, 21'h000001, 21'h400, 21'h400)}},
                r: {4{cv(21'h1FFFFF, 21'h000000, 21'h400, 21'h400)}}, ovf: 1'b0};
    // positive overflow
    vecs[5] = '{t: {cv(21'h800, 0, 0, 0), cv(0, ONE, 0, 0), cv(0, 0, ONE, 0), cv(0, 0, 0, ONE)},
                m: {4{cv(21'h0FFFFF, 0, 0, 21'h400)}},
                r: {4{cv(pos_ovf_v, 0, 0, 21'h400)}}, ovf: 1'b1};
    // negative overflow
    vecs[6] = '{t: {cv(21'h800, 0, 0, 0), cv(0, ONE, 0, 0), cv(0, 0, ONE, 0), cv(0, 0, 0, ONE)},
                m: {4{cv(21'h100000, 0, 0, 21'h400)}},
                r: {4{cv(neg_ovf_v, 0, 0, 21'h400)}}, ovf: 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_mtrx   = '0;
    bus.xf_mtrx   = '0;

    repeat (3) @(negedge clk);
    check_i("rst_in_ready", int'(bus.in_ready), 1);
    check_i("rst_out_valid", int'(bus.out_valid), 0);
    check_i("rst_out_ovf", int'(bus.out_ovf), 0);
    check_m("rst_out_mtrx", bus.out_mtrx, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start_job(vecs[i].t, vecs[i].m);
      wait_done(lat);
      check_i($sformatf("v%0d_latency", i), lat, 16);
      check_m($sformatf("v%0d_out_mtrx", i), bus.out_mtrx, vecs[i].r);
      check_i($sformatf("v%0d_out_ovf", i), int'(bus.out_ovf), int'(vecs[i].ovf));
      check_i($sformatf("v%0d_in_ready_done", i), int'(bus.in_ready), 0);
      handshake();
      check_m($sformatf("v%0d_hold_after_hs", i), bus.out_mtrx, vecs[i].r);
    end

    // backpressure: result holds for 10 cycles, then a second job right behind it
    start_job(vecs[1].t, vecs[1].m);
    wait_done(lat);
    check_i("bp_latency", lat, 16);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_i("bp_out_valid", int'(bus.out_valid), 1);
      check_i("bp_in_ready", int'(bus.in_ready), 0);
      check_m("bp_out_mtrx", bus.out_mtrx, vecs[1].r);
    end
    handshake();
    start_job(vecs[2].t, vecs[2].m);
    wait_done(lat);
    check_i("bp2_latency", lat, 16);
    check_m("bp2_out_mtrx", bus.out_mtrx, vecs[2].r);
    handshake();

    // reset at idx=7 of an overflowing job, then a clean job
    start_job(vecs[5].t, vecs[5].m);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_i("midrst_out_valid", int'(bus.out_valid), 0);
    check_m("midrst_out_mtrx", bus.out_mtrx, '0);
    check_i("midrst_out_ovf", int'(bus.out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_i("midrst_in_ready", int'(bus.in_ready), 1);
    check_i("midrst_out_valid_after", int'(bus.out_valid), 0);
    start_job(vecs[0].t, vecs[0].m);
    wait_done(lat);
    check_i("postrst_latency", lat, 16);
    check_m("postrst_out_mtrx", bus.out_mtrx, vecs[0].r);
    check_i("postrst_out_ovf", int'(bus.out_ovf), 0);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
